instr_pair_queue: RTL and testbench

- Fetch-side instruction queue sitting directly upstream of the dual-issue IDU.
- Accepts 1 or 2 fetched instructions per cycle with their PC. Presents the two oldest entries as the instruction pair `instr1`/`instr2` to the IDU.
- Retires 0, 1 or 2 entries per cycle according to the issue count the IDU returns.
- A flush input empties the queue on branch redirect.

---
 rtl/instr_pair_queue_if.sv | 38 +++
 rtl/instr_pair_queue.sv | 99 +++++++++
 tb/tb_instr_pair_queue.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_pair_queue_if.sv
// Fetch/IDU-facing signal bundle for the instruction pair queue.
// Handshake: a push transfers on a clock edge when in_valid && in_ready
// && in_cnt is 1 or 2. in_ready depends only on registered occupancy.
// The IDU consumes entries by returning issue_cnt. It may only issue
// entries flagged by instr1_valid/instr2_valid. Any excess is clipped.
interface instr_pair_queue_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          flush;
    logic          in_valid;
    logic [1:0]    in_cnt;
    logic [31:0]   in_instr1;
    logic [31:0]   in_instr2;
    logic [31:0]   in_pc;
    logic          in_ready;
    logic [31:0]   instr1;
    logic [31:0]   instr2;
    logic [31:0]   pc1;
    logic [31:0]   pc2;
    logic          instr1_valid;
    logic          instr2_valid;
    logic [1:0]    issue_cnt;
    logic [CW-1:0] count;

    // Fetch/IDU side: drives pushes, flush and issue count.
    modport master (
        output flush, in_valid, in_cnt, in_instr1, in_instr2, in_pc, issue_cnt,
        input  in_ready, instr1, instr2, pc1, pc2, instr1_valid, instr2_valid, count
    );

    // Queue side.
    modport slave (
        input  flush, in_valid, in_cnt, in_instr1, in_instr2, in_pc, issue_cnt,
        output in_ready, instr1, instr2, pc1, pc2, instr1_valid, instr2_valid, count
    );
endinterface

// File: rtl/instr_pair_queue.sv
// Fetch-side instruction queue feeding a dual-issue decoder. It accepts
// 1 or 2 instructions per cycle and presents the two oldest entries as a
// pair. It retires 0..2 entries per cycle and empties on flush or reset.
module instr_pair_queue #(
    parameter int          DEPTH = 8,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic               Clk,
    input  logic               Rst,
    instr_pair_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Highest occupancy that still leaves room for a full pair.
    localparam logic [CW-1:0] PAIR_ROOM_MAX = CW'(DEPTH - 2);

    logic [31:0]   r_mem_instr [DEPTH];
    logic [31:0]   r_mem_pc    [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [AW-1:0] w_wr_ptr1;
    logic [AW-1:0] w_rd_ptr1;
    logic          w_in_ready;
    logic [1:0]    w_push_n;
    logic [1:0]    w_issue_sat;
    logic [1:0]    w_eff_pop;
    logic          w_clear;
    logic          w_has1;
    logic          w_has2;

    assign w_wr_ptr1 = r_wr_ptr + AW'(1);
    assign w_rd_ptr1 = r_rd_ptr + AW'(1);
    assign w_clear   = Rst || bus.flush;
    assign w_has1    = (r_count != '0);
    assign w_has2    = (r_count >= CW'(2));

    // Ready is conservative: it requires room for a pair even for a single push.
    assign w_in_ready = (r_count <= PAIR_ROOM_MAX);

    // Decode the accepted push size. Illegal counts 0 and 3 push nothing.
    always_comb begin
        w_push_n = 2'd0;
        if (bus.in_valid && w_in_ready) begin
            if (bus.in_cnt == 2'd1) begin
                w_push_n = 2'd1;
            end else if (bus.in_cnt == 2'd2) begin
                w_push_n = 2'd2;
            end
        end
    end

    // Clip the issue count to 2, then to current occupancy, so count never underflows.
    always_comb begin
        w_issue_sat = (bus.issue_cnt == 2'd3) ? 2'd2 : bus.issue_cnt;
        w_eff_pop   = w_issue_sat;
        if (CW'(w_issue_sat) > r_count) begin
            w_eff_pop = r_count[1:0];
        end
    end

    // Pointer and occupancy update. Flush and reset discard any same-cycle push or pop.
    always_ff @(posedge Clk) begin
        if (w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push_n);
            r_rd_ptr <= r_rd_ptr + AW'(w_eff_pop);
            r_count  <= r_count + CW'(w_push_n) - CW'(w_eff_pop);
        end
    end

    // Entry storage. It is not reset, because only occupied slots are ever presented.
    always_ff @(posedge Clk) begin
        if (!w_clear && (w_push_n != 2'd0)) begin
            r_mem_instr[r_wr_ptr] <= bus.in_instr1;
            r_mem_pc[r_wr_ptr]    <= bus.in_pc;
            if (w_push_n == 2'd2) begin
                r_mem_instr[w_wr_ptr1] <= bus.in_instr2;
                r_mem_pc[w_wr_ptr1]    <= bus.in_pc + 32'd4;
            end
        end
    end

    // Present the head pair directly from registered state. Empty slots show NOP and PC 0.
    always_comb begin
        bus.instr1       = w_has1 ? r_mem_instr[r_rd_ptr]  : NOP;
        bus.pc1          = w_has1 ? r_mem_pc[r_rd_ptr]     : 32'd0;
        bus.instr2       = w_has2 ? r_mem_instr[w_rd_ptr1] : NOP;
        bus.pc2          = w_has2 ? r_mem_pc[w_rd_ptr1]    : 32'd0;
        bus.instr1_valid = w_has1;
        bus.instr2_valid = w_has2;
        bus.count        = r_count;
        bus.in_ready     = w_in_ready;
    end
endmodule

// File: tb/tb_instr_pair_queue.sv
// Bench for instr_pair_queue: directed vector table, hand sequences for
// fill/wrap/flush/reset, then random traffic, all against a queue model.
module tb_instr_pair_queue;
    localparam int          DEPTH = 8;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic clk;
    logic rst;

    instr_pair_queue_if #(.DEPTH(DEPTH)) bus ();

    instr_pair_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    // Clock and reset generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the queue contents. Each entry is {instr, pc}, oldest at the front.
    logic [63:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        fl;
        logic        vld;
        logic [1:0]  cnt;
        logic [31:0] i1;
        logic [31:0] i2;
        logic [31:0] pc;
        logic [1:0]  iss;
        int          e_count;
        logic [31:0] e_i1;
        logic [31:0] e_pc1;
        logic [31:0] e_i2;
        logic [31:0] e_pc2;
        logic        e_rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Compare all outputs with the model's head entries.
    task automatic check_model(input string tag);
        int n;
        logic [31:0] e_i1, e_pc1, e_i2, e_pc2;
        n = exp_q.size();
        e_i1 = NOP; e_pc1 = 32'd0; e_i2 = NOP; e_pc2 = 32'd0;
        if (n >= 1) begin
            e_i1  = exp_q[0][63:32];
            e_pc1 = exp_q[0][31:0];
        end
        if (n >= 2) begin
            e_i2  = exp_q[1][63:32];
            e_pc2 = exp_q[1][31:0];
        end
        chk({tag, ".count"},    32'(bus.count), 32'(n));
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'((DEPTH - n) >= 2));
        chk({tag, ".v1"},       32'(bus.instr1_valid), 32'(n >= 1));
        chk({tag, ".v2"},       32'(bus.instr2_valid), 32'(n >= 2));
        chk({tag, ".instr1"},   bus.instr1, e_i1);
        chk({tag, ".pc1"},      bus.pc1, e_pc1);
        chk({tag, ".instr2"},   bus.instr2, e_i2);
        chk({tag, ".pc2"},      bus.pc2, e_pc2);
    endtask

    // Driver task for one clock cycle. It applies the inputs, checks the current outputs,
    // updates the model and advances past the edge.
    task automatic cycle(input logic r, input logic fl, input logic vld, input logic [1:0] cnt,
                         input logic [31:0] i1, input logic [31:0] i2, input logic [31:0] pc,
                         input logic [1:0] iss, input string tag);
        int n, pop;
        logic rdy;
        rst = r;
        bus.flush = fl;
        bus.in_valid = vld;
        bus.in_cnt = cnt;
        bus.in_instr1 = i1;
        bus.in_instr2 = i2;
        bus.in_pc = pc;
        bus.issue_cnt = iss;
        #1;
        if (!rst) check_model(tag);
        n = exp_q.size();
        rdy = ((DEPTH - n) >= 2);
        if (r || fl) begin
            exp_q.delete();
        end else begin
            pop = (iss == 2'd3) ? 2 : int'(iss);
            if (pop > n) pop = n;
            repeat (pop) void'(exp_q.pop_front());
            if (vld && rdy && (cnt == 2'd1 || cnt == 2'd2)) begin
                exp_q.push_back({i1, pc});
                if (cnt == 2'd2) exp_q.push_back({i2, pc + 32'd4});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [1:0] iss, input string tag);
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, iss, tag);
    endtask

    task automatic push2(input logic [1:0] iss, input string tag);
        logic [31:0] a, b, pc;
        a = $urandom; b = $urandom; pc = {$urandom_range(0, 65535), 2'b00};
        cycle(1'b0, 1'b0, 1'b1, 2'd2, a, b, pc, iss, tag);
    endtask

    task automatic push1(input logic [1:0] iss, input string tag);
        logic [31:0] a, pc;
        a = $urandom; pc = {$urandom_range(0, 65535), 2'b00};
        cycle(1'b0, 1'b0, 1'b1, 2'd1, a, 32'd0, pc, iss, tag);
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_cnt = 2'd0;
        bus.in_instr1 = '0; bus.in_instr2 = '0; bus.in_pc = '0; bus.issue_cnt = 2'd0;

        // Directed vectors. The expected outputs are those after the row's clock edge.
        vecs.push_back('{1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd0, 0, NOP, 32'h0, NOP, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 2'd2, 32'h00200093, 32'h00300113, 32'h100, 2'd0,
                         2, 32'h00200093, 32'h100, 32'h00300113, 32'h104, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 2'd1, 32'h00408093, 32'h0, 32'h108, 2'd1,
                         2, 32'h00300113, 32'h104, 32'h00408093, 32'h108, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd2, 0, NOP, 32'h0, NOP, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd2, 0, NOP, 32'h0, NOP, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 2'd3, 32'h11, 32'h22, 32'h40, 2'd0, 0, NOP, 32'h0, NOP, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 32'h11, 32'h22, 32'h40, 2'd0, 0, NOP, 32'h0, NOP, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 2'd1, 32'h00500193, 32'h0, 32'h200, 2'd0,
                         1, 32'h00500193, 32'h200, NOP, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd2, 0, NOP, 32'h0, NOP, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd0, 0, NOP, 32'h0, NOP, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 2'd2, 32'h00600213, 32'h00700293, 32'h300, 2'd0,
                         2, 32'h00600213, 32'h300, 32'h00700293, 32'h304, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 2'd1, 32'h00800313, 32'h0, 32'h308, 2'd3,
                         1, 32'h00800313, 32'h308, NOP, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd1, 0, NOP, 32'h0, NOP, 32'h0, 1'b1});

        // Reset, then check the idle state.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        chk("reset.count",    32'(bus.count), 32'd0);
        chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset.instr1",   bus.instr1, NOP);
        chk("reset.instr2",   bus.instr2, NOP);
        chk("reset.v1",       32'(bus.instr1_valid), 32'd0);
        chk("reset.v2",       32'(bus.instr2_valid), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(1'b0, vecs[i].fl, vecs[i].vld, vecs[i].cnt, vecs[i].i1, vecs[i].i2,
                  vecs[i].pc, vecs[i].iss, $sformatf("vec%0d.pre", i));
            chk($sformatf("vec%0d.count", i),    32'(bus.count), 32'(vecs[i].e_count));
            chk($sformatf("vec%0d.instr1", i),   bus.instr1, vecs[i].e_i1);
            chk($sformatf("vec%0d.pc1", i),      bus.pc1, vecs[i].e_pc1);
            chk($sformatf("vec%0d.instr2", i),   bus.instr2, vecs[i].e_i2);
            chk($sformatf("vec%0d.pc2", i),      bus.pc2, vecs[i].e_pc2);
            chk($sformatf("vec%0d.in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_rdy));
        end

        // Fill to full with pair pushes, try an extra push, then drain one per cycle with wrap.
        for (int i = 0; i < 4; i++) push2(2'd0, $sformatf("fill%0d", i));
        chk("full.count",    32'(bus.count), 32'(DEPTH));
        chk("full.in_ready", 32'(bus.in_ready), 32'd0);
        push2(2'd0, "full.extra");
        chk("full.extra_ignored", 32'(bus.count), 32'(DEPTH));
        idle(2'd1, "drain0");
        chk("seven.in_ready", 32'(bus.in_ready), 32'd0);
        push1(2'd0, "seven.push1");
        chk("seven.push1_ignored", 32'(bus.count), 32'(DEPTH - 1));
        for (int i = 1; i < DEPTH; i++) idle(2'd1, $sformatf("drain%0d", i));
        chk("drained.count", 32'(bus.count), 32'd0);

        // Flush at count 3 together with a push and a pop.
        push2(2'd0, "fl.a");
        push1(2'd0, "fl.b");
        chk("fl.count3", 32'(bus.count), 32'd3);
        cycle(1'b0, 1'b1, 1'b1, 2'd2, 32'hdeadbeef, 32'hcafef00d, 32'h500, 2'd2, "fl.go");
        chk("fl.count",  32'(bus.count), 32'd0);
        chk("fl.instr1", bus.instr1, NOP);
        chk("fl.v1",     32'(bus.instr1_valid), 32'd0);

        // Reset mid-operation with a push in flight.
        push2(2'd0, "rs.a");
        cycle(1'b1, 1'b0, 1'b1, 2'd2, 32'h1, 32'h2, 32'h600, 2'd0, "rs.go");
        rst = 1'b0;
        chk("rs.count",  32'(bus.count), 32'd0);
        chk("rs.instr2", bus.instr2, NOP);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            logic r, f;
            r = ($urandom_range(0, 59) == 0);
            f = ($urandom_range(0, 24) == 0);
            cycle(r, f, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                  {$urandom_range(0, 65535), 2'b00}, 2'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
        end
        rst = 1'b0;
        idle(2'd0, "final");
        check_model("end");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
